// File: rtl/fpadd_norm.sv
// fpadd_norm: post-add normalize / round / pack stage of the FP adder, 2-stage valid/ready pipeline.
// Optional build macro: FPADD_NORM_ROUND_EN selects round-to-nearest-even (truncation otherwise).
`default_nettype none

module fpadd_norm #(
  parameter int wE = 4,
  parameter int wF = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [wE-1:0]    in_exp,
  input  logic [wF+3:0]    in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [wE+wF:0]   out_res,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int MW  = wF + 2;
  localparam int LZW = $clog2(wF + 3);
  localparam int EW  = ((wE + 1 > LZW) ? wE + 1 : LZW) + 2;
  localparam logic [EW-1:0] EMAX = EW'((1 << wE) - 1);

  logic            w_adv;
  logic [MW:0]     w_m1;
  logic [wE:0]     w_e1;
  logic [LZW-1:0]  w_lz;
  logic            w_zero;

  logic            v1_q;
  logic            sign1_q;
  logic            zero1_q;
  logic [wE:0]     e1_q;
  logic [MW:0]     m1_q;
  logic [LZW-1:0]  lz1_q;

  logic            out_valid_q;
  logic [wE+wF:0]  res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  assign w_adv     = !out_valid_q || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = out_valid_q;
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

  // Carry-out: shift right one and fold the dropped guard into sticky; else count leading zeros on {h,f,g}.
  always_comb begin
    w_m1 = in_mant[MW:0];
    w_e1 = {1'b0, in_exp};
    w_lz = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (in_mant[i+1]) w_lz = LZW'(MW - 1 - i);
    end
    if (in_mant[wF+3]) begin
      w_m1 = {1'b1, in_mant[wF+2:2], in_mant[1] | in_mant[0]};
      w_e1 = {1'b0, in_exp} + 1'b1;
      w_lz = '0;
    end
    w_zero = ~|w_m1;
  end

  logic [MW-1:0]  w_sh;
  logic [wF:0]    w_sig;
  logic [EW-1:0]  w_en;
  logic [EW-1:0]  w_enr;
  logic [wF-1:0]  w_frac;
  logic           w_unused;
  logic           w_unf;
  logic           w_ovf;

  assign w_sh  = m1_q[MW:1] << lz1_q;
  assign w_sig = w_sh[MW-1:1];
  assign w_en  = EW'(e1_q) - EW'(lz1_q);

`ifdef FPADD_NORM_ROUND_EN
  logic        w_inc;
  logic [wF+1:0] w_sum;
  assign w_inc    = w_sh[0] & (m1_q[0] | w_sig[0]);
  assign w_sum    = {1'b0, w_sig} + (wF+2)'(w_inc);
  // A carry past the hidden bit leaves the fraction at zero and bumps the exponent.
  assign w_frac   = w_sum[wF+1] ? '0 : w_sum[wF-1:0];
  assign w_enr    = w_en + EW'(w_sum[wF+1]);
  assign w_unused = w_sum[wF];
`else
  assign w_frac   = w_sig[wF-1:0];
  assign w_enr    = w_en;
  assign w_unused = ^{w_sh[0], m1_q[0], w_sig[wF]};
`endif

  assign w_unf = w_enr[EW-1] || (w_enr == '0);
  assign w_ovf = !w_unf && (w_enr > EMAX);

  always_comb begin
    res_d = {sign1_q, w_enr[wE-1:0], w_frac};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (zero1_q) begin
      res_d = '0;
    end else if (w_unf) begin
      res_d = {sign1_q, {(wE+wF){1'b0}}};
      unf_d = 1'b1;
    end else if (w_ovf) begin
      res_d = {sign1_q, {(wE+wF){1'b1}}};
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      zero1_q     <= 1'b0;
      e1_q        <= '0;
      m1_q        <= '0;
      lz1_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (w_adv) begin
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (in_valid) begin
        sign1_q <= in_sign;
        zero1_q <= w_zero;
        e1_q    <= w_e1;
        m1_q    <= w_m1;
        lz1_q   <= w_lz;
      end
      if (v1_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpadd_norm.sv
// tb_fpadd_norm: scoreboard bench for fpadd_norm; expected results come from an arithmetic reference model.
`default_nettype none

module tb_fpadd_norm;

  localparam int WE = 4;
  localparam int WF = 5;
  localparam int RW = WE + WF + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [WE-1:0] in_exp = '0;
  logic [WF+3:0] in_mant = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_res;
  logic          out_ovf;
  logic          out_unf;

  fpadd_norm #(.wE(WE), .wF(WF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW+1:0] sb[$];
  bit  bp_rand = 1'b0;
  bit  arm_stall = 1'b0;
  int  stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: value-level normalize, round and classify; result packed as {ovf, unf, res}.
  function automatic logic [RW+1:0] model(input logic sg, input int ex, input int mt);
    int c, s, m, e, lz, sig;
    logic [RW+1:0] r;
    c = (mt >> (WF + 3)) & 1;
    s = mt & 1;
    m = (mt >> 1) & ((1 << (WF + 2)) - 1);
    e = ex;
    if (c == 0 && m == 0 && s == 0) return '0;
    if (c == 1) begin
      s = s | (m & 1);
      m = (m >> 1) | (1 << (WF + 1));
      e = e + 1;
    end else begin
      lz = 0;
      while (lz < WF + 2 && ((m >> (WF + 1 - lz)) & 1) == 0) lz++;
      m = (m << lz) & ((1 << (WF + 2)) - 1);
      e = e - lz;
    end
    sig = m >> 1;
`ifdef FPADD_NORM_ROUND_EN
    begin
      int g;
      g = m & 1;
      if (g == 1 && (s == 1 || (sig & 1) == 1)) sig++;
      if (sig >= (1 << (WF + 1))) begin
        sig = 0;
        e = e + 1;
      end
    end
`endif
    if (e <= 0)                 r = {2'b01, sg, {(RW-1){1'b0}}};
    else if (e > (1 << WE) - 1) r = {2'b10, sg, {(RW-1){1'b1}}};
    else                        r = {2'b00, sg, e[WE-1:0], sig[WF-1:0]};
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic sg, input int ex, input int mt, input logic [RW+1:0] exp_r);
    int waited;
    in_valid = 1'b1;
    in_sign  = sg;
    in_exp   = WE'(ex);
    in_mant  = (WF+4)'(mt);
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        check("accept_timeout", 32'(waited), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(exp_r);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic sg;
    int ex, mt;
    sg = 1'($urandom_range(0, 1));
    ex = $urandom_range(0, (1 << WE) - 1);
    mt = $urandom_range(0, (1 << (WF + 4)) - 1) >> $urandom_range(0, WF + 3);
    send(sg, ex, mt, model(sg, ex, mt));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (arm_stall && out_valid) begin
        arm_stall  = 1'b0;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin
    bit prev_stall;
    logic [RW+1:0] held;
    logic [RW+1:0] e;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_hold", 32'(out_valid), 32'd1);
          check("stall_data_hold", 32'({out_ovf, out_unf, out_res}), 32'(held));
        end
        if (out_valid && !out_ready)
          check("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 32'({out_ovf, out_unf, out_res}), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("result", 32'({out_ovf, out_unf, out_res}), 32'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        held = {out_ovf, out_unf, out_res};
      end
    end
  end

  initial begin
    int stale, cyc;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", 32'(out_res), 32'd0);
    check("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases from the plan.
    send(1'b0, 7, 9'b1_0_10100_0_0, {2'b00, 10'b0_1000_01010});
    send(1'b0, 7, 9'b0_0_00110_1_0, {2'b00, 10'b0_0100_10100});
`ifdef FPADD_NORM_ROUND_EN
    send(1'b0, 3,  9'b0_1_00001_1_0, {2'b00, 10'b0_0011_00010});
    send(1'b0, 5,  9'b0_1_11111_1_1, {2'b00, 10'b0_0110_00000});
    send(1'b0, 15, 9'b0_1_11111_1_1, {2'b10, 10'b0_1111_11111});
`else
    send(1'b0, 3,  9'b0_1_00001_1_0, {2'b00, 10'b0_0011_00001});
    send(1'b0, 5,  9'b0_1_11111_1_1, {2'b00, 10'b0_0101_11111});
    send(1'b0, 15, 9'b0_1_11111_1_1, {2'b00, 10'b0_1111_11111});
`endif
    send(1'b1, 15, 9'b1_0_00000_0_0, {2'b10, 10'b1_1111_11111});
    send(1'b1, 2,  9'b0_0_00100_0_0, {2'b01, 10'b1_0000_00000});
    send(1'b1, 9,  9'b0_0_00000_0_0, {2'b00, 10'b0_0000_00000});
    idle(4);

    // Back-to-back burst with a 3-cycle downstream stall on the first result.
    arm_stall = 1'b1;
    repeat (4) send_rand();
    idle(8);

    // Random traffic with random gaps and random backpressure.
    bp_rand = 1'b1;
    repeat (300) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    bp_rand = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 2000) begin idle(1); cyc++; end
    check("drain_left", 32'(sb.size()), 32'd0);

    // Asynchronous reset with two beats in flight.
    send_rand();
    send_rand();
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_after_rst", 32'(stale), 32'd0);
    idle(1);
    send(1'b0, 7, 9'b0_0_00110_1_0, {2'b00, 10'b0_0100_10100});
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin idle(1); cyc++; end
    check("post_rst_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpadd_norm.md
Name: fpadd_norm

Overview:
- Back-end of the custom floating-point adder: the post-add normalize / round / pack stage.
- The front-end swap block orders the operands and produces the larger exponent and the exponent difference. After alignment and the mantissa add/sub, this block takes the raw sum and emits the packed result.
- 2-stage pipeline with valid/ready handshake on both sides.
- Number format: {sign, exp[wE-1:0], frac[wF-1:0]} with implicit hidden bit.
  - exp==0 means zero.
  - No denormals; underflow flushes to zero.
  - exp all-ones is a normal finite value.

Parameters:
- wE, 4, exponent field width.
- wF, 5, fraction field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sign  in  1  sign of the sum.
- in_exp  in  wE  larger (reference) operand exponent, unbiased field value.
- in_mant  in  wF+4  raw sum {c, h, f[wF-1:0], g, s}:
  - c = carry-out, h = hidden bit, f = fraction, g = guard, s = sticky.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  wE+wF+1  packed result {sign, exp, frac}.
- out_ovf  out  1  result saturated (valid with out_valid).
- out_unf  out  1  result flushed to zero by underflow (valid with out_valid).

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_res=0, out_ovf=0, out_unf=0, all stage-valid flags 0. Pipeline contents are discarded, including mid-operation.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - Both stages advance together when adv=1.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_res and flags hold stable and no input is taken.
  - Latency: exactly 2 cycles from input accept to out_valid with no stall. Throughput 1 beat/cycle.
- Stage 1 (register on adv):
  - c=1: shift right 1. h'=c, f'={h, f[wF-1:1]}, g'=f[0], s'=g|s, e1=in_exp+1 (wE+1 bits).
  - c=0: lz = leading-zero count over {h, f, g}, range 0..wF+2, where wF+2 means all zero. e1=in_exp. Mantissa passes through unchanged.
  - Also register sign, a zero flag (all of h, f, g, s zero) and lz.
- Stage 2 (register on adv):
  - Left-shift {h, f, g} by lz, filling with zeros; s is unchanged. en = e1 - lz, signed.
  - Rounding is round-to-nearest-even (see optional feature).
  - inc = g & (s | f[0]). Fraction plus inc; if it carries out of the hidden bit, frac=0 and en+1.
- Output selection, in priority order:
  1. Zero flag set: out_res = all 0, sign=0, no flags.
  2. en<=0 (underflow): out_res = {sign, 0...}, out_unf=1.
  3. en>2^wE-1 (overflow): out_res = {sign, all-ones exp, all-ones frac}, out_ovf=1.
  4. Otherwise: {sign, en[wE-1:0], frac}.
- Overflow can come from the carry path or from the rounding carry. Both saturate.

Optional Feature:
- FPADD_NORM_ROUND_EN defined: round-to-nearest-even as described above.
- Not defined: truncation. inc is forced to 0, g and s are ignored, and the rounding carry path is absent.
- Zero, underflow and overflow handling are identical in both builds.

Test Plan (wE=4, wF=5; mant written as c h fffff g s):
- Carry normalize: exp=7, mant=0 0_10100_0_0 with c=1 (i.e. 1 0 10100 0 0), sign=0 -> out_res=0_1000_01010 two cycles after accept, flags 0.
- Left normalize: exp=7, mant=0 0 00110 1 0 -> lz=3, out_res=0_0100_10100.
- RNE tie: exp=3, mant=0 1 00001 1 0 -> with FPADD_NORM_ROUND_EN: 0_0011_00010; without: 0_0011_00001. Round carry case: exp=5, mant=0 1 11111 1 1 -> 0_0110_00000.
- Overflow: sign=1, exp=15, c=1 -> out_res=1_1111_11111, out_ovf=1. Underflow: sign=1, exp=2, mant=0 0 00100 0 0 (lz=3) -> 1_0000_00000, out_unf=1. Exact zero: mant all 0 -> 0_0000_00000.
- Backpressure: stream 4 beats back-to-back, out_ready low 3 cycles after first out_valid -> out_res held, in_ready=0, no beat lost or duplicated, order preserved.
- Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid drops immediately, and no stale results appear after release.
